// File: rtl/risc16_mem_pkg.sv
// Shared types and constants for the risc16 memory arbiter.
// Widths, LED MMIO defaults and the arbiter state encoding.
package risc16_mem_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int WADDR_W = ADDR_W - 1;

  localparam logic [ADDR_W-1:0] LED_ADDR0_DEF = 16'h0200;
  localparam logic [ADDR_W-1:0] LED_ADDR1_DEF = 16'h0202;

  typedef enum logic [1:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR
  } arb_state_t;

endpackage

// File: rtl/risc16_mem_arbiter_if.sv
// Core-side fetch/data ports, SRAM port and LED outputs of the arbiter.
// slave is the arbiter view, master the core/SRAM/harness view.
interface risc16_mem_arbiter_if;
  import risc16_mem_pkg::*;

  logic [ADDR_W-1:0]  iaddr;
  logic               ioe;
  logic [DATA_W-1:0]  idin;
  logic               i_ready;
  logic [ADDR_W-1:0]  daddr;
  logic [DATA_W-1:0]  ddout;
  logic               doe;
  logic               dwe0;
  logic               dwe1;
  logic [DATA_W-1:0]  ddin;
  logic               d_ready;
  logic [WADDR_W-1:0] maddr;
  logic [DATA_W-1:0]  mdout;
  logic [DATA_W-1:0]  mdin;
  logic               moe;
  logic [1:0]         mwe;
  logic [23:0]        led;

  modport slave (
    input  iaddr, ioe, daddr, ddout, doe, dwe0, dwe1, mdin,
    output idin, i_ready, ddin, d_ready,
    output maddr, mdout, moe, mwe, led
  );

  modport master (
    output iaddr, ioe, daddr, ddout, doe, dwe0, dwe1, mdin,
    input  idin, i_ready, ddin, d_ready,
    input  maddr, mdout, moe, mwe, led
  );

endinterface

// File: rtl/risc16_mmio_led.sv
// LED MMIO block: three byte registers, write decode and read mux.
// Word 0 holds {led_1, led_0}; word 1 holds {8'h00, led_2}.
module risc16_mmio_led
  import risc16_mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR0 = LED_ADDR0_DEF,
  parameter logic [ADDR_W-1:0] ADDR1 = LED_ADDR1_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [WADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               be0,
  input  logic               be1,
  output logic               hit,
  output logic [DATA_W-1:0]  rdata,
  output logic [23:0]        led
);

  logic [7:0] led0_q, led0_d;
  logic [7:0] led1_q, led1_d;
  logic [7:0] led2_q, led2_d;
  logic       sel0, sel1;

  always_comb begin
    sel0   = waddr == ADDR0[ADDR_W-1:1];
    sel1   = waddr == ADDR1[ADDR_W-1:1];
    hit    = sel0 | sel1;
    led0_d = led0_q;
    led1_d = led1_q;
    led2_d = led2_q;
    if (we && sel0 && be1) led0_d = wdata[7:0];
    if (we && sel0 && be0) led1_d = wdata[15:8];
    // even byte of word 1 has no register behind it
    if (we && sel1 && be1) led2_d = wdata[7:0];
    unique case (1'b1)
      sel0:    rdata = {led1_q, led0_q};
      sel1:    rdata = {8'h00, led2_q};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      led0_q <= '0;
      led1_q <= '0;
      led2_q <= '0;
    end else begin
      led0_q <= led0_d;
      led1_q <= led1_d;
      led2_q <= led2_d;
    end
  end

  assign led = {led2_q, led1_q, led0_q};

endmodule

// File: rtl/risc16_mem_arbiter.sv
// Shares one single-port SRAM between fetch and data ports of risc16.
// Data wins by default; fetch is forced in after STARVE_LIMIT data grants.
module risc16_mem_arbiter
  import risc16_mem_pkg::*;
#(
  parameter int                STARVE_LIMIT = 4,
  parameter logic [ADDR_W-1:0] LED_ADDR0    = LED_ADDR0_DEF,
  parameter logic [ADDR_W-1:0] LED_ADDR1    = LED_ADDR1_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  risc16_mem_arbiter_if.slave  bus
);

  localparam int            SW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  arb_state_t         state_q, state_d;
  logic [SW-1:0]      starve_q, starve_d;
  logic [WADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0]  mdout_q, mdout_d;
  logic               mmio_q, mmio_d;
  logic [DATA_W-1:0]  rdat_q, rdat_d;

  logic               d_req, d_wr, idle;
  logic               gnt_i, gnt_d, hit, led_we;
  logic [WADDR_W-1:0] dword;
  logic [DATA_W-1:0]  led_rdata;
  logic               unused_bits;

  assign unused_bits = bus.iaddr[0] ^ bus.daddr[0];
  assign dword       = bus.daddr[ADDR_W-1:1];

  always_comb begin
    d_req  = bus.doe | bus.dwe0 | bus.dwe1;
    d_wr   = bus.dwe0 | bus.dwe1;
    idle   = rst && (state_q == IDLE);
    gnt_i  = idle && bus.ioe && (!d_req || starve_q == LIM);
    gnt_d  = idle && d_req && !gnt_i;
    led_we = gnt_d && d_wr && hit;
  end

  risc16_mmio_led #(
    .ADDR0 (LED_ADDR0),
    .ADDR1 (LED_ADDR1)
  ) u_led (
    .clk   (clk),
    .rst   (rst),
    .we    (led_we),
    .waddr (dword),
    .wdata (bus.ddout),
    .be0   (bus.dwe0),
    .be1   (bus.dwe1),
    .hit   (hit),
    .rdata (led_rdata),
    .led   (bus.led)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      maddr_q  <= '0;
      mdout_q  <= '0;
      mmio_q   <= 1'b0;
      rdat_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      maddr_q  <= maddr_d;
      mdout_q  <= mdout_d;
      mmio_q   <= mmio_d;
      rdat_q   <= rdat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    maddr_d  = maddr_q;
    mdout_d  = mdout_q;
    mmio_d   = mmio_q;
    rdat_d   = rdat_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_i)      state_d = I_RD;
        else if (gnt_d) state_d = d_wr ? D_WR : D_RD;
      end
      default: state_d = IDLE;
    endcase
    if (!bus.ioe || gnt_i)
      starve_d = '0;
    else if (gnt_d && starve_q != LIM)
      starve_d = starve_q + SW'(1);
    if (gnt_i) maddr_d = bus.iaddr[ADDR_W-1:1];
    if (gnt_d) begin
      mmio_d = hit;
      rdat_d = led_rdata;
      if (!hit) maddr_d = dword;
      if (!hit && d_wr) mdout_d = bus.ddout;
    end
  end

  always_comb begin
    bus.maddr   = '0;
    bus.mdout   = '0;
    bus.moe     = 1'b0;
    bus.mwe     = 2'b00;
    bus.idin    = '0;
    bus.ddin    = '0;
    bus.i_ready = 1'b0;
    bus.d_ready = 1'b0;
    // holding reset also masks a ready from an access in flight
    if (rst) begin
      bus.maddr = maddr_q;
      bus.mdout = mdout_q;
      unique case (state_q)
        IDLE: begin
          if (gnt_i) begin
            bus.maddr = bus.iaddr[ADDR_W-1:1];
            bus.moe   = 1'b1;
          end else if (gnt_d && !hit) begin
            bus.maddr = dword;
            if (d_wr) begin
              bus.mdout = bus.ddout;
              bus.mwe   = {bus.dwe0, bus.dwe1};
            end else begin
              bus.moe = 1'b1;
            end
          end
        end
        I_RD: begin
          bus.idin    = bus.mdin;
          bus.i_ready = 1'b1;
        end
        D_RD: begin
          bus.ddin    = mmio_q ? rdat_q : bus.mdin;
          bus.d_ready = 1'b1;
        end
        D_WR:    bus.d_ready = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
